// File: rtl/code_defs_pkg.sv
// Shared XGMII control characters and 64b/66b block-coding constants for the PCS transmit path.
package code_defs_pkg;

   localparam logic [7:0] RS_IDLE  = 8'h07;
   localparam logic [7:0] RS_START = 8'hFB;
   localparam logic [7:0] RS_TERM  = 8'hFD;
   localparam logic [7:0] RS_ERROR = 8'hFE;

   localparam logic [1:0] SYNC_DATA = 2'b01;
   localparam logic [1:0] SYNC_CTL  = 2'b10;

   localparam logic [7:0] BT_IDLE = 8'h1E;
   localparam logic [7:0] BT_S0   = 8'h78;
   localparam logic [7:0] BT_S4   = 8'h33;
   localparam logic [7:0] BT_T0   = 8'h87;
   localparam logic [7:0] BT_T1   = 8'h99;
   localparam logic [7:0] BT_T2   = 8'hAA;
   localparam logic [7:0] BT_T3   = 8'hB4;
   localparam logic [7:0] BT_T4   = 8'hCC;
   localparam logic [7:0] BT_T5   = 8'hD2;
   localparam logic [7:0] BT_T6   = 8'hE1;
   localparam logic [7:0] BT_T7   = 8'hFF;

   localparam logic [6:0] CC_IDLE  = 7'h00;
   localparam logic [6:0] CC_ERROR = 7'h1E;

   // Only called on lanes already known to be IDLE or ERROR; anything else maps to ERROR.
   function automatic logic [6:0] rs_to_cc(input logic [7:0] c);
      return (c == RS_IDLE) ? CC_IDLE : CC_ERROR;
   endfunction

   function automatic logic [7:0] bt_term(input int k);
      case (k)
         0:       return BT_T0;
         1:       return BT_T1;
         2:       return BT_T2;
         3:       return BT_T3;
         4:       return BT_T4;
         5:       return BT_T5;
         6:       return BT_T6;
         default: return BT_T7;
      endcase
   endfunction

endpackage

// File: rtl/encode_64b66b_block.sv
// Combinational 64b/66b block encoder: one 64-bit XGMII block (8 lanes) to sync header + payload.
module encode_64b66b_block
   import code_defs_pkg::*;
(
   input  logic [63:0] data64,
   input  logic [7:0]  ctl8,
   output logic [1:0]  header,
   output logic [63:0] payload
);

   logic [7:0]  ie;
   logic [55:0] codes;
   logic [7:0]  lo_mask;
   logic [7:0]  hi_mask;
   logic        term_ok;
   logic [63:0] term_pay;

   always_comb begin
      ie       = '0;
      codes    = '0;
      lo_mask  = '0;
      hi_mask  = '0;
      term_ok  = 1'b0;
      term_pay = '0;

      for (int m = 0; m < 8; m++) begin
         ie[m] = ctl8[m] && ((data64[8*m +: 8] == RS_IDLE) || (data64[8*m +: 8] == RS_ERROR));
         codes[7*m +: 7] = rs_to_cc(data64[8*m +: 8]);
      end

      // Lane m's 7-bit code sits at bit 8+7m for both idle and terminate blocks.
      for (int k = 0; k < 8; k++) begin
         lo_mask = (8'h01 << k) - 8'h01;
         hi_mask = ~((8'h02 << k) - 8'h01);
         if (((ctl8 & lo_mask) == 8'h00) && ctl8[k] && (data64[8*k +: 8] == RS_TERM) &&
             ((ie & hi_mask) == hi_mask)) begin
            term_ok  = 1'b1;
            term_pay = {codes, bt_term(k)};
            for (int m = 0; m < 8; m++) begin
               if (m <= k) term_pay[8 + 7*m +: 7] = 7'h00;
            end
            for (int i = 0; i < 56; i++) begin
               if (i < 8*k) term_pay[8 + i] = data64[i];
            end
         end
      end

      header  = SYNC_CTL;
      payload = {{8{CC_ERROR}}, BT_IDLE};
      if (ctl8 == 8'h00) begin
         header  = SYNC_DATA;
         payload = data64;
      end else if ((ctl8 == 8'hFF) && (&ie)) begin
         payload = {codes, BT_IDLE};
      end else if ((ctl8 == 8'h01) && (data64[7:0] == RS_START)) begin
         payload = {data64[63:8], BT_S0};
      end else if ((ctl8 == 8'h1F) && (data64[31:0] == {4{RS_IDLE}}) && (data64[39:32] == RS_START)) begin
         payload = {data64[63:40], 4'b0000, codes[27:0], BT_S4};
      end else if (term_ok) begin
         payload = term_pay;
      end
   end

endmodule

// File: rtl/tx_encoder_32b.sv
// 32-bit transmit 64b/66b encoder: pairs XGMII words into blocks and emits each encoded block as two halves.
module tx_encoder_32b
   import code_defs_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] xgmii_tx_data,
   input  logic [3:0]  xgmii_tx_ctl,
   output logic        phy_tx_ready,
   input  logic        encoded_tx_ready,
   output logic [31:0] encoded_tx_data,
   output logic [1:0]  encoded_tx_header,
   output logic        encoded_tx_header_valid
);

   logic        h_q, h_d;
   logic [31:0] lo_data_q, lo_data_d;
   logic [3:0]  lo_ctl_q, lo_ctl_d;
   logic [31:0] hi_hold_q, hi_hold_d;
   logic [31:0] out_data_q, out_data_d;
   logic [1:0]  out_hdr_q, out_hdr_d;
   logic        out_hv_q, out_hv_d;

   logic [1:0]  enc_header;
   logic [63:0] enc_payload;

   encode_64b66b_block u_encode (
      .data64  ({xgmii_tx_data, lo_data_q}),
      .ctl8    ({xgmii_tx_ctl, lo_ctl_q}),
      .header  (enc_header),
      .payload (enc_payload)
   );

   assign phy_tx_ready = encoded_tx_ready;

   // h=0 captures the low word and emits the held high half; h=1 encodes and emits the low half.
   always_comb begin
      h_d        = h_q;
      lo_data_d  = lo_data_q;
      lo_ctl_d   = lo_ctl_q;
      hi_hold_d  = hi_hold_q;
      out_data_d = out_data_q;
      out_hdr_d  = out_hdr_q;
      out_hv_d   = out_hv_q;
      if (encoded_tx_ready) begin
         h_d = ~h_q;
         if (!h_q) begin
            lo_data_d  = xgmii_tx_data;
            lo_ctl_d   = xgmii_tx_ctl;
            out_data_d = hi_hold_q;
            out_hv_d   = 1'b0;
         end else begin
            out_data_d = enc_payload[31:0];
            hi_hold_d  = enc_payload[63:32];
            out_hdr_d  = enc_header;
            out_hv_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         h_q        <= 1'b0;
         hi_hold_q  <= '0;
         out_data_q <= '0;
         out_hdr_q  <= 2'b00;
         out_hv_q   <= 1'b0;
      end else begin
         h_q        <= h_d;
         hi_hold_q  <= hi_hold_d;
         out_data_q <= out_data_d;
         out_hdr_q  <= out_hdr_d;
         out_hv_q   <= out_hv_d;
      end
   end

   // A stale low word is harmless: after reset h=0 so it is overwritten before use.
   always_ff @(posedge clk) begin
      lo_data_q <= lo_data_d;
      lo_ctl_q  <= lo_ctl_d;
   end

   assign encoded_tx_data         = out_data_q;
   assign encoded_tx_header       = out_hdr_q;
   assign encoded_tx_header_valid = out_hv_q;

endmodule

// File: tb/tb_tx_encoder_32b.sv
// Directed-vector bench for tx_encoder_32b with hand-computed block encodings.
module tb_tx_encoder_32b;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] xgmii_tx_data;
   logic [3:0]  xgmii_tx_ctl;
   logic        phy_tx_ready;
   logic        encoded_tx_ready;
   logic [31:0] encoded_tx_data;
   logic [1:0]  encoded_tx_header;
   logic        encoded_tx_header_valid;

   int n_vec = 0;
   int n_bad = 0;

   localparam logic [31:0] IDLE_W = 32'h07070707;

   tx_encoder_32b dut (
      .clk                     (clk),
      .reset                   (reset),
      .xgmii_tx_data           (xgmii_tx_data),
      .xgmii_tx_ctl            (xgmii_tx_ctl),
      .phy_tx_ready            (phy_tx_ready),
      .encoded_tx_ready        (encoded_tx_ready),
      .encoded_tx_data         (encoded_tx_data),
      .encoded_tx_header       (encoded_tx_header),
      .encoded_tx_header_valid (encoded_tx_header_valid)
   );

   always #5 clk = ~clk;

   wire [34:0] obs_lo = {encoded_tx_header_valid, encoded_tx_header, encoded_tx_data};
   wire [32:0] obs_hi = {encoded_tx_header_valid, encoded_tx_data};

   task automatic apply(input logic [31:0] d, input logic [3:0] c, input logic rdy);
      xgmii_tx_data    = d;
      xgmii_tx_ctl     = c;
      encoded_tx_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      apply(IDLE_W, 4'hF, 1'b1);
      apply(IDLE_W, 4'hF, 1'b1);
      n_vec++;
      if (obs_lo !== 35'h0) begin n_bad++; $display("FAIL reset_out: got %h expected %h", obs_lo, 35'h0); end
      reset = 1'b0;
      apply(IDLE_W, 4'hF, 1'b1);
      n_vec++;
      if (obs_hi !== 33'h0) begin n_bad++; $display("FAIL reset_first_word: got %h expected %h", obs_hi, 33'h0); end
      apply(IDLE_W, 4'hF, 1'b1);
      n_vec++;
      if (obs_lo !== {1'b1, 2'b10, 32'h0000001E}) begin n_bad++; $display("FAIL idle_lo: got %h expected %h", obs_lo, {1'b1, 2'b10, 32'h0000001E}); end
      apply(IDLE_W, 4'hF, 1'b1);
      n_vec++;
      if (obs_hi !== {1'b0, 32'h00000000}) begin n_bad++; $display("FAIL idle_hi: got %h expected %h", obs_hi, {1'b0, 32'h0}); end
      apply(IDLE_W, 4'hF, 1'b1);
   endtask

   task automatic test_start;
      apply(32'h555555FB, 4'h1, 1'b1);
      apply(32'hD5555555, 4'h0, 1'b1);
      n_vec++;
      if (obs_lo !== {1'b1, 2'b10, 32'h55555578}) begin n_bad++; $display("FAIL start_lo: got %h expected %h", obs_lo, {1'b1, 2'b10, 32'h55555578}); end
      apply(IDLE_W, 4'hF, 1'b1);
      n_vec++;
      if (obs_hi !== {1'b0, 32'hD5555555}) begin n_bad++; $display("FAIL start_hi: got %h expected %h", obs_hi, {1'b0, 32'hD5555555}); end
      apply(IDLE_W, 4'hF, 1'b1);
   endtask

   task automatic test_start4;
      apply(IDLE_W, 4'hF, 1'b1);
      apply(32'h332211FB, 4'h1, 1'b1);
      n_vec++;
      if (obs_lo !== {1'b1, 2'b10, 32'h00000033}) begin n_bad++; $display("FAIL s4_lo: got %h expected %h", obs_lo, {1'b1, 2'b10, 32'h00000033}); end
      apply(IDLE_W, 4'hF, 1'b1);
      n_vec++;
      if (obs_hi !== {1'b0, 32'h33221100}) begin n_bad++; $display("FAIL s4_hi: got %h expected %h", obs_hi, {1'b0, 32'h33221100}); end
      apply(IDLE_W, 4'hF, 1'b1);
   endtask

   task automatic test_data;
      apply(32'h04030201, 4'h0, 1'b1);
      apply(32'h08070605, 4'h0, 1'b1);
      n_vec++;
      if (obs_lo !== {1'b1, 2'b01, 32'h04030201}) begin n_bad++; $display("FAIL data_lo: got %h expected %h", obs_lo, {1'b1, 2'b01, 32'h04030201}); end
      apply(IDLE_W, 4'hF, 1'b1);
      n_vec++;
      if (obs_hi !== {1'b0, 32'h08070605}) begin n_bad++; $display("FAIL data_hi: got %h expected %h", obs_hi, {1'b0, 32'h08070605}); end
      apply(IDLE_W, 4'hF, 1'b1);
   endtask

   task automatic test_terminate;
      // T3 followed by idles
      apply(32'hFD332211, 4'h8, 1'b1);
      apply(IDLE_W, 4'hF, 1'b1);
      n_vec++;
      if (obs_lo !== {1'b1, 2'b10, 32'h332211B4}) begin n_bad++; $display("FAIL t3_lo: got %h expected %h", obs_lo, {1'b1, 2'b10, 32'h332211B4}); end
      apply(IDLE_W, 4'hF, 1'b1);
      n_vec++;
      if (obs_hi !== {1'b0, 32'h00000000}) begin n_bad++; $display("FAIL t3_hi: got %h expected %h", obs_hi, {1'b0, 32'h0}); end
      apply(IDLE_W, 4'hF, 1'b1);
      // T3 with ERROR in lane 4
      apply(32'hFD332211, 4'h8, 1'b1);
      apply(32'h070707FE, 4'hF, 1'b1);
      n_vec++;
      if (obs_lo !== {1'b1, 2'b10, 32'h332211B4}) begin n_bad++; $display("FAIL t3e_lo: got %h expected %h", obs_lo, {1'b1, 2'b10, 32'h332211B4}); end
      apply(IDLE_W, 4'hF, 1'b1);
      n_vec++;
      if (obs_hi !== {1'b0, 32'h000001E0}) begin n_bad++; $display("FAIL t3e_hi: got %h expected %h", obs_hi, {1'b0, 32'h000001E0}); end
      apply(IDLE_W, 4'hF, 1'b1);
      // T0
      apply(32'h070707FD, 4'hF, 1'b1);
      apply(IDLE_W, 4'hF, 1'b1);
      n_vec++;
      if (obs_lo !== {1'b1, 2'b10, 32'h00000087}) begin n_bad++; $display("FAIL t0_lo: got %h expected %h", obs_lo, {1'b1, 2'b10, 32'h00000087}); end
      apply(IDLE_W, 4'hF, 1'b1);
      n_vec++;
      if (obs_hi !== {1'b0, 32'h00000000}) begin n_bad++; $display("FAIL t0_hi: got %h expected %h", obs_hi, {1'b0, 32'h0}); end
      apply(IDLE_W, 4'hF, 1'b1);
      // T7
      apply(32'h44332211, 4'h0, 1'b1);
      apply(32'hFD776655, 4'h8, 1'b1);
      n_vec++;
      if (obs_lo !== {1'b1, 2'b10, 32'h332211FF}) begin n_bad++; $display("FAIL t7_lo: got %h expected %h", obs_lo, {1'b1, 2'b10, 32'h332211FF}); end
      apply(IDLE_W, 4'hF, 1'b1);
      n_vec++;
      if (obs_hi !== {1'b0, 32'h77665544}) begin n_bad++; $display("FAIL t7_hi: got %h expected %h", obs_hi, {1'b0, 32'h77665544}); end
      apply(IDLE_W, 4'hF, 1'b1);
   endtask

   task automatic test_invalid;
      apply(32'h00000007, 4'h1, 1'b1);
      apply(32'h00000000, 4'h0, 1'b1);
      n_vec++;
      if (obs_lo !== {1'b1, 2'b10, 32'hC78F1E1E}) begin n_bad++; $display("FAIL inv_lo: got %h expected %h", obs_lo, {1'b1, 2'b10, 32'hC78F1E1E}); end
      apply(IDLE_W, 4'hF, 1'b1);
      n_vec++;
      if (obs_hi !== {1'b0, 32'h3C78F1E3}) begin n_bad++; $display("FAIL inv_hi: got %h expected %h", obs_hi, {1'b0, 32'h3C78F1E3}); end
      apply(IDLE_W, 4'hF, 1'b1);
      // unknown control character in an otherwise idle block
      apply(32'h0707079C, 4'hF, 1'b1);
      apply(IDLE_W, 4'hF, 1'b1);
      n_vec++;
      if (obs_lo !== {1'b1, 2'b10, 32'hC78F1E1E}) begin n_bad++; $display("FAIL unk_lo: got %h expected %h", obs_lo, {1'b1, 2'b10, 32'hC78F1E1E}); end
      apply(IDLE_W, 4'hF, 1'b1);
      apply(IDLE_W, 4'hF, 1'b1);
   endtask

   task automatic test_back_to_back;
      apply(32'h04030201, 4'h0, 1'b1);
      apply(32'h08070605, 4'h0, 1'b1);
      n_vec++;
      if (obs_lo !== {1'b1, 2'b01, 32'h04030201}) begin n_bad++; $display("FAIL b2b_a_lo: got %h expected %h", obs_lo, {1'b1, 2'b01, 32'h04030201}); end
      apply(32'hFD332211, 4'h8, 1'b1);
      n_vec++;
      if (obs_hi !== {1'b0, 32'h08070605}) begin n_bad++; $display("FAIL b2b_a_hi: got %h expected %h", obs_hi, {1'b0, 32'h08070605}); end
      apply(IDLE_W, 4'hF, 1'b1);
      n_vec++;
      if (obs_lo !== {1'b1, 2'b10, 32'h332211B4}) begin n_bad++; $display("FAIL b2b_b_lo: got %h expected %h", obs_lo, {1'b1, 2'b10, 32'h332211B4}); end
      apply(IDLE_W, 4'hF, 1'b1);
      n_vec++;
      if (obs_hi !== {1'b0, 32'h00000000}) begin n_bad++; $display("FAIL b2b_b_hi: got %h expected %h", obs_hi, {1'b0, 32'h0}); end
      apply(IDLE_W, 4'hF, 1'b1);
   endtask

   task automatic test_stall;
      apply(32'h04030201, 4'h0, 1'b1);
      xgmii_tx_data    = 32'hDEADBEEF;
      xgmii_tx_ctl     = 4'hF;
      encoded_tx_ready = 1'b0;
      #1;
      n_vec++;
      if (phy_tx_ready !== 1'b0) begin n_bad++; $display("FAIL stall_phy_ready_lo: got %b expected %b", phy_tx_ready, 1'b0); end
      @(posedge clk);
      #1;
      n_vec++;
      if (obs_hi !== {1'b0, 32'h00000000}) begin n_bad++; $display("FAIL stall_hold1: got %h expected %h", obs_hi, {1'b0, 32'h0}); end
      encoded_tx_ready = 1'b1;
      #1;
      n_vec++;
      if (phy_tx_ready !== 1'b1) begin n_bad++; $display("FAIL stall_phy_ready_hi: got %b expected %b", phy_tx_ready, 1'b1); end
      apply(32'h08070605, 4'h0, 1'b1);
      n_vec++;
      if (obs_lo !== {1'b1, 2'b01, 32'h04030201}) begin n_bad++; $display("FAIL stall_lo: got %h expected %h", obs_lo, {1'b1, 2'b01, 32'h04030201}); end
      apply(32'h0BADF00D, 4'h3, 1'b0);
      n_vec++;
      if (obs_lo !== {1'b1, 2'b01, 32'h04030201}) begin n_bad++; $display("FAIL stall_hold2: got %h expected %h", obs_lo, {1'b1, 2'b01, 32'h04030201}); end
      apply(IDLE_W, 4'hF, 1'b1);
      n_vec++;
      if (obs_hi !== {1'b0, 32'h08070605}) begin n_bad++; $display("FAIL stall_hi: got %h expected %h", obs_hi, {1'b0, 32'h08070605}); end
      apply(IDLE_W, 4'hF, 1'b1);
   endtask

   task automatic test_reset_mid_block;
      apply(32'hAAAAAAAA, 4'h0, 1'b1);
      reset = 1'b1;
      apply(32'hBBBBBBBB, 4'h0, 1'b1);
      n_vec++;
      if (obs_lo !== 35'h0) begin n_bad++; $display("FAIL midrst_out: got %h expected %h", obs_lo, 35'h0); end
      reset = 1'b0;
      apply(32'h04030201, 4'h0, 1'b1);
      apply(32'h08070605, 4'h0, 1'b1);
      n_vec++;
      if (obs_lo !== {1'b1, 2'b01, 32'h04030201}) begin n_bad++; $display("FAIL midrst_lo: got %h expected %h", obs_lo, {1'b1, 2'b01, 32'h04030201}); end
      apply(IDLE_W, 4'hF, 1'b1);
      n_vec++;
      if (obs_hi !== {1'b0, 32'h08070605}) begin n_bad++; $display("FAIL midrst_hi: got %h expected %h", obs_hi, {1'b0, 32'h08070605}); end
      apply(IDLE_W, 4'hF, 1'b1);
   endtask

   initial begin
      reset            = 1'b1;
      xgmii_tx_data    = IDLE_W;
      xgmii_tx_ctl     = 4'hF;
      encoded_tx_ready = 1'b1;
      test_reset();
      test_idle_start_data();
      test_terminate();
      test_invalid();
      test_back_to_back();
      test_stall();
      test_reset_mid_block();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   task automatic test_idle_start_data;
      test_start();
      test_start4();
      test_data();
   endtask

endmodule

// File: doc/tx_encoder_32b.md
# tx_encoder_32b

Clause 49 64b/66b transmit encoder for the 32-bit datapath. It sits directly downstream of the transmit MAC and upstream of the scrambler/gearbox. It consumes 32-bit XGMII words, pairs them into 64-bit blocks and encodes each block into a 2-bit sync header plus a 64-bit payload. The encoded payload is emitted as two 32-bit halves on consecutive ready cycles. Gearbox back-pressure is passed straight through to the MAC.

## Interface
- No parameters. Data width is fixed at 32 bits and ctl width at 4 bits.
- clk  in  1  datapath clock
- reset  in  1  synchronous, active-high reset
- xgmii_tx_data  in  32  XGMII data from the MAC; lane 0 is in [7:0]
- xgmii_tx_ctl  in  4  XGMII control flags, one per lane
- phy_tx_ready  out  1  ready to the MAC; combinationally equal to encoded_tx_ready
- encoded_tx_ready  in  1  gearbox ready; when low, input is ignored and all state holds
- encoded_tx_data  out  32  payload half: the low half first, then the high half
- encoded_tx_header  out  2  sync header; meaningful only when encoded_tx_header_valid is high
- encoded_tx_header_valid  out  1  high on the cycle that carries the low half of a block

## Operation
- Half counter h (1 bit):
  - Reset value 0.
  - Toggles on each cycle with encoded_tx_ready=1.
  - MAC alignment comes from the shared reset and shared ready. A start code therefore always lands in lane 0 at h=0.
- When h=0 (ready cycle): capture the word and ctl into lo_data/lo_ctl.
- When h=1 (ready cycle): form the block as data64={xgmii_tx_data, lo_data} and ctl8={xgmii_tx_ctl, lo_ctl}, encode it, and register the result.
- Payload bit 0 is transmitted first. For control blocks the type byte occupies bits [7:0].
- Encoding rules:
  - ctl8=0x00: header 01, payload = data64.
  - ctl8=0xFF, every lane IDLE(0x07) or ERROR(0xFE): header 10, type 0x1E, then eight 7-bit codes (IDLE→0x00, ERROR→0x1E).
  - ctl8=0x01, lane0=START(0xFB): type 0x78, followed by D1..D7.
  - ctl8=0x1F, lanes 0–3 IDLE, lane4=START: type 0x33, followed by C0..C3 as 7-bit codes, 4 zero bits, then D5..D7.
  - Terminate in lane k (k=0..7):
    - Required pattern: lanes <k are data, lane k is TERM(0xFD), lanes >k are IDLE or ERROR.
    - Type bytes for k=0..7: 0x87, 0x99, 0xAA, 0xB4, 0xCC, 0xD2, 0xE1, 0xFF.
    - Payload: D0..D(k-1), then (7-k) zero bits, then 7-bit codes for lanes k+1..7.
  - Any other pattern (including unknown control characters): error block, header 10, type 0x1E, all eight codes 0x1E.
- Outputs are fully registered. The high half is held in hi_hold until it is emitted.

## Timing
- Reset:
  - encoded_tx_data=0, encoded_tx_header=2'b00, encoded_tx_header_valid=0.
  - h=0 and any partial block is discarded.
  - Reset mid-block drops the captured low word.
- Latency: word0 enters at ready cycle t and word1 at t+1.
  - The low half with header_valid=1 is visible in ready cycle t+2.
  - The high half with header_valid=0 is visible in ready cycle t+3.
  - Latency is counted in ready cycles only.
- Stall: encoded_tx_ready=0 freezes h, lo_*, hi_hold and all outputs. The input is not sampled. The stall may fall between the two halves of a block.
- header_valid stays 0 until the first complete block is emitted after reset.
- Back-to-back blocks need no bubbles. Throughput is one block per two ready cycles.

## Structure
- code_defs_pkg gains the following constants:
  - sync headers SYNC_DATA=2'b01 and SYNC_CTL=2'b10;
  - block type constants (BT_IDLE 0x1E, BT_S0 0x78, BT_S4 0x33, BT_T0..BT_T7);
  - 7-bit codes CC_IDLE=7'h00 and CC_ERROR=7'h1E.
- The existing RS_IDLE, RS_START, RS_TERM and RS_ERROR definitions are reused.
- One combinational sub-module, encode_64b66b_block, maps (data64, ctl8) to (header, payload64). It is also reusable in 64-bit mode.

## Test plan
- Idle: 0x07070707/ctl F twice → header 10, low half 0x0000001E, high half 0x00000000.
- Start: 0x555555FB/ctl 1, then 0xD5555555/ctl 0 → header 10, low half 0x55555578, high half 0xD5555555.
- Data: 0x04030201, then 0x08070605, both ctl 0 → header 01, low half 0x04030201, high half 0x08070605.
- T3: 0xFD332211/ctl 8, then 0x07070707/ctl F → header 10, low half 0x332211B4, high half 0x00000000.
- Stall: repeat the data case with encoded_tx_ready low for one cycle between the words → identical output one cycle later, outputs held during the stall; phy_tx_ready tracks encoded_tx_ready in the same cycle.
- Invalid and reset:
  - Invalid input: 0x00000007/ctl 1 → error block (type 0x1E, all codes 0x1E).
  - Reset after word0: the next two words form a fresh block; no stale lane data appears.
